// File: rtl/pong_input_pkg.sv
// Shared definitions for the Pong button conditioner: channel map, channel
// count, per-channel debounce state encoding and the paddle command helper.
package pong_input_pkg;

  localparam int NUM_BTN  = 5;
  localparam int BTN_GAME = 0;
  localparam int BTN_UP_L = 1;
  localparam int BTN_DN_L = 2;
  localparam int BTN_UP_R = 3;
  localparam int BTN_DN_R = 4;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    CHK_HIGH    = 2'd1,
    STABLE_HIGH = 2'd2,
    CHK_LOW     = 2'd3
  } db_state_e;

  // {up, down}; holding both buttons cancels to no motion.
  function automatic logic [1:0] paddle_cmd(input logic up, input logic dn);
    return {up & ~dn, dn & ~up};
  endfunction

endpackage

// File: rtl/pong_input_if.sv
// Button bundle between the board pins / VGA monitor and the conditioner.
// master drives the raw buttons; slave is the conditioner.
interface pong_input_if;
  import pong_input_pkg::*;

  logic [NUM_BTN-1:0] raw_btn_n;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [1:0]         paddle_left;
  logic [1:0]         paddle_right;
  logic               game_button;

  modport master (
    output raw_btn_n,
    input  btn_level, btn_press, paddle_left, paddle_right, game_button
  );

  modport slave (
    input  raw_btn_n,
    output btn_level, btn_press, paddle_left, paddle_right, game_button
  );

endinterface

// File: rtl/debounce_cell.sv
// One button channel: 2-flop synchronizer, debounce FSM, press pulse and,
// when PONG_AUTOREPEAT_EN is defined and REPEAT_EN is set, an auto-repeat timer.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// STABLE_LOW  | released; waiting for the synced input to go high
// CHK_HIGH    | input high, counting stable cycles before accepting a press
// STABLE_HIGH | pressed; level high, optional auto-repeat running
// CHK_LOW     | input low, counting stable cycles before accepting release
module debounce_cell
  import pong_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 15000000,
  parameter int REPEAT_PERIOD   = 2500000,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clk_clk,
  input  logic reset_reset,
  input  logic raw_n,
  output logic level,
  output logic press
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 20) - 1 ||
      (REPEAT_EN && (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1))) begin : g_bad_cfg
    $error("debounce_cell: illegal parameter value");
  end

  logic             sync_q1, sync_q2, synced;
  db_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             accept;
  logic             rpt_fire;

  // Synchronizer resets to the released (high) pin level.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= raw_n;
      sync_q2 <= sync_q1;
    end
  end

  assign synced  = ~sync_q2;
  assign cnt_inc = cnt + CNT_W'(1);

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state <= STABLE_LOW;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      press <= accept | rpt_fire;
    end
  end

  // The cycle that leaves a STABLE state is the first stable sample, so the
  // check state finishes when the incremented count reaches DEBOUNCE_CYCLES-1.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    unique case (state)
      STABLE_LOW: begin
        cnt_nxt = '0;
        if (synced) state_nxt = CHK_HIGH;
      end
      CHK_HIGH: begin
        if (!synced) begin
          state_nxt = STABLE_LOW;
          cnt_nxt   = '0;
        end else if (cnt_inc == CNT_LAST) begin
          state_nxt = STABLE_HIGH;
          cnt_nxt   = '0;
          accept    = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      STABLE_HIGH: begin
        cnt_nxt = '0;
        if (!synced) state_nxt = CHK_LOW;
      end
      CHK_LOW: begin
        if (synced) begin
          state_nxt = STABLE_HIGH;
          cnt_nxt   = '0;
        end else if (cnt_inc == CNT_LAST) begin
          state_nxt = STABLE_LOW;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = STABLE_LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign level = (state == STABLE_HIGH) || (state == CHK_LOW);

`ifdef PONG_AUTOREPEAT_EN
  if (REPEAT_EN) begin : g_rpt
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    logic [RPT_W-1:0] rpt_cnt;

    // Down-counter: loaded on STABLE_HIGH entry, fires at zero, then reloads.
    always_ff @(posedge clk_clk) begin
      if (reset_reset || state_nxt != STABLE_HIGH)
        rpt_cnt <= '0;
      else if (state != STABLE_HIGH)
        rpt_cnt <= RPT_W'(REPEAT_DELAY - 1);
      else if (rpt_cnt == '0)
        rpt_cnt <= RPT_W'(REPEAT_PERIOD - 1);
      else
        rpt_cnt <= rpt_cnt - RPT_W'(1);
    end

    assign rpt_fire = (state == STABLE_HIGH) && (state_nxt == STABLE_HIGH) &&
                      (rpt_cnt == '0);
  end else begin : g_no_rpt
    assign rpt_fire = 1'b0;
  end
`else
  assign rpt_fire = 1'b0;
`endif

endmodule

// File: rtl/pong_input_conditioner.sv
// Conditions the five Pong push buttons into debounced levels, press pulses,
// paddle commands and a game-button pulse. Auto-repeat on the paddle
// channels is built only when PONG_AUTOREPEAT_EN is defined.
module pong_input_conditioner
  import pong_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 15000000,
  parameter int REPEAT_PERIOD   = 2500000
) (
  input  logic         clk_clk,
  input  logic         reset_reset,
  pong_input_if.slave  btn_if
);

  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] press;
  logic               game_q;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (i != BTN_GAME)
    ) u_cell (
      .clk_clk     (clk_clk),
      .reset_reset (reset_reset),
      .raw_n       (btn_if.raw_btn_n[i]),
      .level       (level[i]),
      .press       (press[i])
    );
  end

  // The game channel never repeats, so this is exactly one pulse per press.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) game_q <= 1'b0;
    else             game_q <= press[BTN_GAME];
  end

  assign btn_if.btn_level    = level;
  assign btn_if.btn_press    = press;
  assign btn_if.paddle_left  = paddle_cmd(level[BTN_UP_L], level[BTN_DN_L]);
  assign btn_if.paddle_right = paddle_cmd(level[BTN_UP_R], level[BTN_DN_R]);
  assign btn_if.game_button  = game_q;

endmodule

// File: tb/tb_pong_input_conditioner.sv
// Scoreboard bench for pong_input_conditioner: expected pulses are queued as
// stimulus is applied and matched against pulses seen on the outputs.
module tb_pong_input_conditioner;
  import pong_input_pkg::*;

  localparam int DC = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic clk_clk     = 1'b0;
  logic reset_reset = 1'b1;
  int   cyc         = 0;
  int   n_tests     = 0;
  int   n_fail      = 0;
  int   exp_q[$];
  logic [NUM_BTN:0] pv;

  pong_input_if bus ();

  pong_input_conditioner #(
    .DEBOUNCE_CYCLES (DC),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .btn_if      (bus)
  );

  always #5 clk_clk = ~clk_clk;
  always @(posedge clk_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic go_to(input int c);
    while (cyc < c) begin
      @(posedge clk_clk);
      #1;
    end
  endtask

  // Pulse events are encoded as cycle*8 + channel; channel 5 is game_button.
  always @(negedge clk_clk) begin
    pv = {bus.game_button, bus.btn_press};
    for (int i = 0; i <= NUM_BTN; i++) begin
      if (pv[i] === 1'b1) begin
        if (exp_q.size() == 0) chk("unexpected_pulse", cyc * 8 + i, -1);
        else                   chk("pulse", cyc * 8 + i, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d expected below 2000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    bus.raw_btn_n = '1;
    reset_reset   = 1'b1;
    go_to(3);
    chk("rst_level", bus.btn_level, 0);
    chk("rst_press", bus.btn_press, 0);
    chk("rst_pl", bus.paddle_left, 0);
    chk("rst_pr", bus.paddle_right, 0);
    chk("rst_game", bus.game_button, 0);
    reset_reset = 1'b0;
    go_to(10);
    chk("idle_level", bus.btn_level, 0);

    // clean press on up_left
    t0 = cyc;
    bus.raw_btn_n[BTN_UP_L] = 1'b0;
    exp_q.push_back((t0 + 6) * 8 + BTN_UP_L);
    go_to(t0 + 5);
    chk("clean_lvl_early", bus.btn_level[BTN_UP_L], 0);
    go_to(t0 + 6);
    chk("clean_lvl", bus.btn_level[BTN_UP_L], 1);
    chk("clean_pl", bus.paddle_left, 2'b10);
    chk("clean_pr", bus.paddle_right, 2'b00);
    bus.raw_btn_n[BTN_UP_L] = 1'b1;
    go_to(t0 + 20);
    chk("clean_rel_lvl", bus.btn_level, 0);
    chk("clean_sb", exp_q.size(), 0);

    // bouncing up_right, then held
    t0 = cyc;
    for (int k = 0; k < 10; k++) begin
      bus.raw_btn_n[BTN_UP_R] = (k % 2 == 0) ? 1'b0 : 1'b1;
      go_to(t0 + 2 * k + 2);
    end
    bus.raw_btn_n[BTN_UP_R] = 1'b0;
    exp_q.push_back((t0 + 26) * 8 + BTN_UP_R);
    go_to(t0 + 25);
    chk("bounce_lvl_early", bus.btn_level[BTN_UP_R], 0);
    go_to(t0 + 26);
    chk("bounce_lvl", bus.btn_level[BTN_UP_R], 1);
    chk("bounce_pr", bus.paddle_right, 2'b10);
    bus.raw_btn_n[BTN_UP_R] = 1'b1;
    go_to(t0 + 40);
    chk("bounce_sb", exp_q.size(), 0);

    // up_left and down_left together, then release down_left
    t0 = cyc;
    bus.raw_btn_n[BTN_UP_L] = 1'b0;
    bus.raw_btn_n[BTN_DN_L] = 1'b0;
    exp_q.push_back((t0 + 6) * 8 + BTN_UP_L);
    exp_q.push_back((t0 + 6) * 8 + BTN_DN_L);
    go_to(t0 + 6);
    chk("conf_lvl", bus.btn_level[2:1], 2'b11);
    chk("conf_pl_both", bus.paddle_left, 2'b00);
    go_to(t0 + 7);
    bus.raw_btn_n[BTN_DN_L] = 1'b1;
    go_to(t0 + 12);
    chk("conf_pl_hold", bus.paddle_left, 2'b00);
    go_to(t0 + 13);
    chk("conf_pl_up", bus.paddle_left, 2'b10);
    go_to(t0 + 14);
    bus.raw_btn_n[BTN_UP_L] = 1'b1;
`ifdef PONG_AUTOREPEAT_EN
    exp_q.push_back((t0 + 16) * 8 + BTN_UP_L);
`endif
    go_to(t0 + 30);
    chk("conf_rel_lvl", bus.btn_level, 0);
    chk("conf_sb", exp_q.size(), 0);

    // game button held 50 cycles
    t0 = cyc;
    bus.raw_btn_n[BTN_GAME] = 1'b0;
    exp_q.push_back((t0 + 6) * 8 + BTN_GAME);
    exp_q.push_back((t0 + 7) * 8 + NUM_BTN);
    go_to(t0 + 6);
    chk("game_lvl", bus.btn_level[BTN_GAME], 1);
    chk("game_btn_early", bus.game_button, 0);
    go_to(t0 + 50);
    bus.raw_btn_n[BTN_GAME] = 1'b1;
    go_to(t0 + 65);
    chk("game_sb", exp_q.size(), 0);

    // down_right held 30 cycles
    t0 = cyc;
    bus.raw_btn_n[BTN_DN_R] = 1'b0;
    exp_q.push_back((t0 + 6) * 8 + BTN_DN_R);
`ifdef PONG_AUTOREPEAT_EN
    for (int r = 6 + RD; r <= 31; r += RP) exp_q.push_back((t0 + r) * 8 + BTN_DN_R);
`endif
    go_to(t0 + 6);
    chk("rpt_pr", bus.paddle_right, 2'b01);
    go_to(t0 + 30);
    bus.raw_btn_n[BTN_DN_R] = 1'b1;
    go_to(t0 + 45);
    chk("rpt_rel_lvl", bus.btn_level, 0);
    chk("rpt_sb", exp_q.size(), 0);

    // reset in the middle of a debounce count
    t0 = cyc;
    bus.raw_btn_n[BTN_DN_L] = 1'b0;
    exp_q.push_back((t0 + 11) * 8 + BTN_DN_L);
    go_to(t0 + 4);
    reset_reset = 1'b1;
    go_to(t0 + 5);
    chk("rstmid_lvl", bus.btn_level, 0);
    reset_reset = 1'b0;
    go_to(t0 + 10);
    chk("rstmid_lvl_early", bus.btn_level[BTN_DN_L], 0);
    go_to(t0 + 11);
    chk("rstmid_lvl", bus.btn_level[BTN_DN_L], 1);
    chk("rstmid_pl", bus.paddle_left, 2'b01);
    bus.raw_btn_n[BTN_DN_L] = 1'b1;
    go_to(t0 + 25);
    chk("rstmid_sb", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pong_input_conditioner.md
PONG_INPUT_CONDITIONER -- requirements
Module: pong_input_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000, which is the count of stable synchronized cycles needed to accept a level change (5 ms at 50 MHz); legal range 2..2^20-1.
REQ-002 SHALL have parameter REPEAT_DELAY, default 15000000, which is the cycles from accepted press to first auto-repeat pulse.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 2500000, which is the cycles between subsequent auto-repeat pulses.
REQ-004 SHALL have port clk_clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port raw_btn_n, input, 5 bits: asynchronous active-low push buttons; index 0 game, 1 up_left, 2 down_left, 3 up_right, 4 down_right.
REQ-007 SHALL have port btn_level, output, 5 bits: debounced active-high button state, same indexing as raw_btn_n.
REQ-008 SHALL have port btn_press, output, 5 bits: one-cycle pulse per accepted press, plus repeat pulses when enabled.
REQ-009 SHALL have port paddle_left, output, 2 bits: {up,down} command for the VGA monitor left paddle.
REQ-010 SHALL have port paddle_right, output, 2 bits: {up,down} command for the right paddle.
REQ-011 SHALL have port game_button, output, 1 bit: one-cycle pulse to the VGA monitor game-button input.

Function
REQ-012 SHALL pass each raw_btn_n bit through a 2-flop synchronizer, then invert it to active-high.
REQ-013 Each channel SHALL use a FSM with states STABLE_LOW, CHK_HIGH, STABLE_HIGH, CHK_LOW.
REQ-014 STABLE_LOW SHALL go to CHK_HIGH when the synced input is 1; CHK_HIGH SHALL count up, return to STABLE_LOW with counter cleared on any 0, and go to STABLE_HIGH when the counter reaches DEBOUNCE_CYCLES-1; STABLE_HIGH and CHK_LOW SHALL behave symmetrically.
REQ-015 The counter SHALL be ceil(log2(DEBOUNCE_CYCLES)) bits wide, SHALL NOT wrap, and SHALL clear on every state entry.
REQ-016 btn_level SHALL be 1 exactly in STABLE_HIGH and CHK_LOW.
REQ-017 Latency from a clean raw falling edge to the btn_level rise SHALL be 2+DEBOUNCE_CYCLES cycles; btn_press SHALL pulse for 1 cycle in the same cycle btn_level rises.
REQ-018 Release SHALL produce no btn_press pulse.
REQ-019 paddle_left SHALL be {btn_level[1] & ~btn_level[2], btn_level[2] & ~btn_level[1]}; when up and down are both held the output SHALL be 2'b00. paddle_right SHALL be formed the same way from bits 3 and 4.
REQ-020 game_button SHALL equal btn_press[0], registered, so it lands 1 cycle after btn_press[0]; game_button SHALL never auto-repeat.
REQ-021 Channels SHALL be fully independent; simultaneous presses on any set of channels SHALL each produce their own pulse in the same cycle.

Reset
REQ-022 While reset_reset=1 the block SHALL force all FSMs to STABLE_LOW, clear all counters and synchronizer flops to the released value, and drive all outputs to 0.
REQ-023 A button held across reset deassertion SHALL be treated as a new press after 2+DEBOUNCE_CYCLES cycles.
REQ-024 Reset asserted mid-count SHALL abort the count with no pulse.

Configuration
REQ-025 The macro PONG_AUTOREPEAT_EN SHALL control auto-repeat.
REQ-026 With PONG_AUTOREPEAT_EN defined, a paddle channel (1-4) held in STABLE_HIGH SHALL emit a btn_press pulse REPEAT_DELAY cycles after entry, then one every REPEAT_PERIOD cycles, until it leaves STABLE_HIGH; the repeat timer SHALL clear on exit.
REQ-027 Without PONG_AUTOREPEAT_EN, no repeat timer logic SHALL exist and btn_press SHALL pulse only on the accepted press.

Structure
REQ-028 The shared package pong_input_pkg SHALL hold the channel index constants (BTN_GAME, BTN_UP_L, BTN_DN_L, BTN_UP_R, BTN_DN_R), NUM_BTN=5, and the debounce state enum.
REQ-029 The sub-module debounce_cell SHALL implement one channel (synchronizer, FSM, counter, press pulse, optional repeat) and SHALL be instantiated 5 times.

Verification (bench DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-030 Clean press: drive raw_btn_n[1] low at cycle 0 -> btn_level[1]=1 and btn_press[1] pulses at cycle 6, and paddle_left=2'b10.
REQ-031 Bounce: toggle raw_btn_n[3] every 2 cycles for 20 cycles, then hold low -> no pulse during bouncing; exactly one pulse 6 cycles after the hold begins.
REQ-032 Conflict: hold buttons 1 and 2 together -> paddle_left=2'b00; release 2 -> paddle_left=2'b10 after 6 cycles.
REQ-033 Game button: press raw_btn_n[0] for 50 cycles -> exactly one game_button pulse at cycle 7, with or without PONG_AUTOREPEAT_EN.
REQ-034 Auto-repeat (macro defined): hold button 4 for 30 cycles -> btn_press[4] at cycles 6, 16, 19, 22, 25, 28, 31; without the macro, only at cycle 6.
REQ-035 Reset mid-count: press button 2, assert reset at cycle 4 for 1 cycle while holding -> no pulse before reset; pulse 6 cycles after reset deasserts.
